sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Single-clock arbiter sharing the external 256K×16 video SRAM between the background tile fetcher (video port, read-only) and a host port (read/write) in the clk100 domain. It owns every SRAM control pin, sequences fixed-length read and write cycles, and inserts a bus-turnaround cycle after each write. The host port typically carries tilemap and tile uploads. Video has priority; an optional fairness limit bounds host starvation.

## Interface
- ACCESS_CYCLES, 2: strobe cycles per SRAM access (≥1)
- VID_BURST_MAX, 8: max consecutive video grants while host waits (fairness build only)
- clk100  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- vid_req  in  1  video read request; hold with vid_addr until vid_gnt
- vid_addr  in  18  video word address
- vid_gnt  out  1  one-cycle pulse: request accepted, address captured
- vid_rvalid  out  1  one-cycle pulse: vid_rdata valid
- vid_rdata  out  16  read data
- host_req, host_we  in  1 each  request; 1 = write
- host_addr  in  18;  host_wdata  in  16;  host_be  in  2  ([1]=hb, [0]=lb)
- host_gnt, host_rvalid  out  1 each;  host_rdata  out  16
- ram_addr  out  18;  ram_dout  out  16;  ram_din  in  16
- ram_ce, ram_oe, ram_we  out  1 each  active-high strobes
- ram_lb, ram_hb  out  1 each  byte enables

## Operation
- States: IDLE, READ, WRITE, TURN.
- IDLE: candidates are vid_req and host_req. Video wins ties. The winner's address, data and byte enables are registered, and the winner's gnt pulses in the next cycle.
- READ: ce=oe=1, we=0, lb=hb=1. It lasts ACCESS_CYCLES cycles. ram_din is sampled at the closing edge and presented on the owner's rdata, with rvalid high for one cycle.
- Back-to-back reads: on a read's closing edge, a pending request is accepted on the same edge. Sustained throughput is one access per ACCESS_CYCLES cycles.
- WRITE: ce=we=1, oe=0, ram_dout=host_wdata, lb/hb=host_be. It lasts ACCESS_CYCLES cycles, then goes to TURN.
- TURN: one cycle with all strobes 0, then IDLE.
- host_be=0 write: the cycle runs normally with lb=hb=0.
- Video requests are always reads. The video port has no write path.
- rdata holds its value until the next read for that port completes.
- A request still asserted in its gnt cycle is not re-accepted, because the arbiter is busy. Requesters drop or change req on seeing gnt.

## Timing
- Reset values: ram_addr=0, ram_dout=0, ce/oe/we/lb/hb=0, all gnt/rvalid=0, all rdata=0, state=IDLE, fairness count=0.
- Read: accept edge T → gnt high in cycle T+1 → strobes cycles T+1..T+N (N=ACCESS_CYCLES) → rvalid high in cycle T+N+1.
- Write: accept edge T → strobes cycles T+1..T+N → TURN cycle T+N+1 → next accept no earlier than edge T+N+1.
- Reset mid-access: strobes drop at the reset edge. No rvalid is issued for the aborted access. A gnt already issued is not repeated.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Configuration
- SRAM_ARB_FAIRNESS_EN defined:
  - A counter increments on each video grant made while host_req is high.
  - When the counter reaches VID_BURST_MAX, the next arbitration grants host even if vid_req is high.
  - The counter clears on a host grant, or on any cycle host_req is low.
- SRAM_ARB_FAIRNESS_EN undefined: strict video priority, no counter, VID_BURST_MAX unused.

## Structure
- Package sram_arb_pkg:
  - state enum (IDLE/READ/WRITE/TURN)
  - owner constants OWNER_VID/OWNER_HOST
  - SRAM_AW=18, SRAM_DW=16
- Sub-module sram_arb_select: winner selection plus the fairness counter under the macro. Its inputs are both reqs and an accept strobe; its output is the owner id.
- The top level holds the access FSM, the strobe counter and the capture registers.

## Test plan
- Reset, then a single video read at addr 0x00123 with ram_din=0xBEEF (N=2) → vid_gnt at T+1, oe/ce high cycles T+1..T+2, vid_rvalid at T+3 with vid_rdata=0xBEEF, host outputs unchanged.
- Both ports request in the same cycle → vid_gnt first. After the video read closes, host_gnt follows on the same closing edge with no idle cycle.
- Host write 0x00010←0xA55A with be=2'b01 → we high 2 cycles, lb=1, hb=0, ram_dout=0xA55A, then a TURN cycle with all strobes 0 before the next accept.
- Fairness build, VID_BURST_MAX=8, vid_req and host_req held high continuously → exactly 8 video grants, then 1 host grant, repeating. Non-fairness build → zero host grants.
- reset asserted during the second strobe cycle of a read → strobes 0 at the next edge, no rvalid, all outputs at reset values.
- Continuous video reads, 100 addresses → one vid_rvalid every ACCESS_CYCLES cycles, data in address order.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the video SRAM arbiter.
// Optional fairness limit elsewhere is controlled by SRAM_ARB_FAIRNESS_EN.
package sram_arb_pkg;

    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        TURN  = 2'd3
    } arb_state_t;

    localparam logic OWNER_VID  = 1'b0;
    localparam logic OWNER_HOST = 1'b1;

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: video port, host port and SRAM pins of the arbiter.
// master = arbiter side, slave = requesters plus SRAM device side.
interface sram_arbiter_if;
    import sram_arb_pkg::*;

    logic               vid_req;
    logic [SRAM_AW-1:0] vid_addr;
    logic               vid_gnt;
    logic               vid_rvalid;
    logic [SRAM_DW-1:0] vid_rdata;

    logic               host_req;
    logic               host_we;
    logic [SRAM_AW-1:0] host_addr;
    logic [SRAM_DW-1:0] host_wdata;
    logic [1:0]         host_be;
    logic               host_gnt;
    logic               host_rvalid;
    logic [SRAM_DW-1:0] host_rdata;

    logic [SRAM_AW-1:0] ram_addr;
    logic [SRAM_DW-1:0] ram_dout;
    logic [SRAM_DW-1:0] ram_din;
    logic               ram_ce;
    logic               ram_oe;
    logic               ram_we;
    logic               ram_lb;
    logic               ram_hb;

    modport master (
        input  vid_req, vid_addr,
        input  host_req, host_we, host_addr, host_wdata, host_be,
        input  ram_din,
        output vid_gnt, vid_rvalid, vid_rdata,
        output host_gnt, host_rvalid, host_rdata,
        output ram_addr, ram_dout, ram_ce, ram_oe, ram_we, ram_lb, ram_hb
    );

    modport slave (
        output vid_req, vid_addr,
        output host_req, host_we, host_addr, host_wdata, host_be,
        output ram_din,
        input  vid_gnt, vid_rvalid, vid_rdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  ram_addr, ram_dout, ram_ce, ram_oe, ram_we, ram_lb, ram_hb
    );

endinterface

// File: rtl/sram_arb_select.sv
// sram_arb_select: picks the owner of the next SRAM access.
// Video wins by default; with SRAM_ARB_FAIRNESS_EN defined a burst counter
// forces a host grant after VID_BURST_MAX video grants made while host waits.
module sram_arb_select
    import sram_arb_pkg::*;
#(
    parameter int VID_BURST_MAX = 8
) (
    input  logic clk100,
    input  logic reset,
    input  logic vidReq,
    input  logic hostReq,
    input  logic accept,
    output logic owner
);

`ifdef SRAM_ARB_FAIRNESS_EN
    localparam int            CW    = $clog2(VID_BURST_MAX + 1);
    localparam logic [CW-1:0] LIMIT = CW'(VID_BURST_MAX);

    logic [CW-1:0] burstCnt;
    logic          hostDue;

    // host is owed the slot once the video burst limit has been reached
    always_comb begin
        hostDue = hostReq && (burstCnt >= LIMIT);
        owner   = (vidReq && !hostDue) ? OWNER_VID : OWNER_HOST;
    end

    // count video grants made while host waits; any host grant or idle host clears
    always_ff @(posedge clk100) begin
        if (reset) begin
            burstCnt <= '0;
        end else if (!hostReq) begin
            burstCnt <= '0;
        end else if (accept) begin
            if (owner == OWNER_HOST) begin
                burstCnt <= '0;
            end else if (burstCnt < LIMIT) begin
                burstCnt <= burstCnt + 1'b1;
            end
        end
    end
`else
    logic unusedSel;

    // strict video priority
    always_comb begin
        owner = vidReq ? OWNER_VID : OWNER_HOST;
    end

    assign unusedSel = ^{clk100, reset, hostReq, accept, (VID_BURST_MAX == 0)};
`endif

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the 256Kx16 video SRAM between the tile fetcher
// (read-only video port) and the host port. Fixed-length strobed accesses,
// one turnaround cycle after every write, all outputs registered.
// Build option: SRAM_ARB_FAIRNESS_EN bounds host starvation (see sram_arb_select).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int VID_BURST_MAX = 8
) (
    input logic            clk100,
    input logic            reset,
    sram_arbiter_if.master bus
);

    localparam int            SW   = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [SW-1:0] LAST = SW'(ACCESS_CYCLES - 1);

    arb_state_t    state;
    logic [SW-1:0] strbCnt;
    logic          curOwner;

    logic vidCand;
    logic hostCand;
    logic closing;
    logic canAccept;
    logic accept;
    logic readDone;
    logic selOwner;

    // a port whose gnt is showing is still holding its old request; ignore it
    always_comb begin
        vidCand   = bus.vid_req  && !bus.vid_gnt;
        hostCand  = bus.host_req && !bus.host_gnt;
        closing   = (strbCnt == LAST);
        readDone  = (state == READ) && closing;
        canAccept = (state == IDLE) || readDone;
        accept    = canAccept && (vidCand || hostCand);
    end

    sram_arb_select #(
        .VID_BURST_MAX(VID_BURST_MAX)
    ) u_select (
        .clk100 (clk100),
        .reset  (reset),
        .vidReq (vidCand),
        .hostReq(hostCand),
        .accept (accept),
        .owner  (selOwner)
    );

    // access sequencer: state, strobe cycle counter and current owner
    always_ff @(posedge clk100) begin
        if (reset) begin
            state    <= IDLE;
            strbCnt  <= '0;
            curOwner <= OWNER_VID;
        end else if (accept) begin
            state    <= (selOwner == OWNER_HOST && bus.host_we) ? WRITE : READ;
            strbCnt  <= '0;
            curOwner <= selOwner;
        end else begin
            case (state)
                READ: begin
                    if (closing) state <= IDLE;
                    else         strbCnt <= strbCnt + 1'b1;
                end
                WRITE: begin
                    if (closing) state <= TURN;
                    else         strbCnt <= strbCnt + 1'b1;
                end
                TURN:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // SRAM pins: capture winner's address/data/enables, drop strobes at close
    always_ff @(posedge clk100) begin
        if (reset) begin
            bus.ram_addr <= '0;
            bus.ram_dout <= '0;
            bus.ram_ce   <= 1'b0;
            bus.ram_oe   <= 1'b0;
            bus.ram_we   <= 1'b0;
            bus.ram_lb   <= 1'b0;
            bus.ram_hb   <= 1'b0;
        end else if (accept) begin
            bus.ram_ce <= 1'b1;
            if (selOwner == OWNER_VID) begin
                bus.ram_addr <= bus.vid_addr;
                bus.ram_oe   <= 1'b1;
                bus.ram_we   <= 1'b0;
                bus.ram_lb   <= 1'b1;
                bus.ram_hb   <= 1'b1;
            end else begin
                bus.ram_addr <= bus.host_addr;
                if (bus.host_we) begin
                    bus.ram_dout <= bus.host_wdata;
                    bus.ram_oe   <= 1'b0;
                    bus.ram_we   <= 1'b1;
                    bus.ram_lb   <= bus.host_be[0];
                    bus.ram_hb   <= bus.host_be[1];
                end else begin
                    bus.ram_oe   <= 1'b1;
                    bus.ram_we   <= 1'b0;
                    bus.ram_lb   <= 1'b1;
                    bus.ram_hb   <= 1'b1;
                end
            end
        end else if (closing && (state == READ || state == WRITE)) begin
            bus.ram_ce <= 1'b0;
            bus.ram_oe <= 1'b0;
            bus.ram_we <= 1'b0;
            bus.ram_lb <= 1'b0;
            bus.ram_hb <= 1'b0;
        end
    end

    // requester handshake: one-cycle grant pulses and read data return
    always_ff @(posedge clk100) begin
        if (reset) begin
            bus.vid_gnt     <= 1'b0;
            bus.host_gnt    <= 1'b0;
            bus.vid_rvalid  <= 1'b0;
            bus.host_rvalid <= 1'b0;
            bus.vid_rdata   <= '0;
            bus.host_rdata  <= '0;
        end else begin
            bus.vid_gnt     <= accept && (selOwner == OWNER_VID);
            bus.host_gnt    <= accept && (selOwner == OWNER_HOST);
            bus.vid_rvalid  <= readDone && (curOwner == OWNER_VID);
            bus.host_rvalid <= readDone && (curOwner == OWNER_HOST);
            if (readDone && curOwner == OWNER_VID)  bus.vid_rdata  <= bus.ram_din;
            if (readDone && curOwner == OWNER_HOST) bus.host_rdata <= bus.ram_din;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vector table plus multi-cycle sequences for sram_arbiter.
module tb_sram_arbiter;

    logic clk100;
    logic reset;

    sram_arbiter_if bus();

    sram_arbiter #(
        .ACCESS_CYCLES(2),
        .VID_BURST_MAX(8)
    ) dut (
        .clk100(clk100),
        .reset (reset),
        .bus   (bus)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

`ifdef SRAM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    typedef struct packed {
        logic        vg;
        logic        vv;
        logic [15:0] vd;
        logic        hg;
        logic        hv;
        logic [15:0] hd;
        logic [17:0] ad;
        logic [15:0] dout;
        logic        ce;
        logic        oe;
        logic        we;
        logic        lb;
        logic        hb;
    } outs_t;

    typedef struct {
        logic        vr;
        logic [17:0] va;
        logic        hr;
        logic        hw;
        logic [17:0] ha;
        logic [15:0] hdat;
        logic [1:0]  be;
        logic [15:0] din;
        outs_t       exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic        useModel;
    logic [15:0] dinVec;

    // SRAM contents model: data is a fixed function of the address
    function automatic logic [15:0] memWord(input logic [17:0] a);
        return a[15:0] ^ 16'hC3A5;
    endfunction

    assign bus.ram_din = useModel ? memWord(bus.ram_addr) : dinVec;

    function automatic vec_t mk(
        input logic vr, input logic [17:0] va, input logic hr, input logic hw,
        input logic [17:0] ha, input logic [15:0] hdat, input logic [1:0] be, input logic [15:0] din,
        input logic vg, input logic vv, input logic [15:0] vd,
        input logic hg, input logic hv, input logic [15:0] hd,
        input logic [17:0] ad, input logic [15:0] dout,
        input logic ce, input logic oe, input logic we, input logic lb, input logic hb);
        vec_t v;
        v.vr = vr; v.va = va; v.hr = hr; v.hw = hw; v.ha = ha; v.hdat = hdat; v.be = be; v.din = din;
        v.exp = '{vg: vg, vv: vv, vd: vd, hg: hg, hv: hv, hd: hd, ad: ad, dout: dout,
                  ce: ce, oe: oe, we: we, lb: lb, hb: hb};
        return v;
    endfunction

    function automatic outs_t sample();
        outs_t s;
        s.vg = bus.vid_gnt;  s.vv = bus.vid_rvalid;  s.vd = bus.vid_rdata;
        s.hg = bus.host_gnt; s.hv = bus.host_rvalid; s.hd = bus.host_rdata;
        s.ad = bus.ram_addr; s.dout = bus.ram_dout;
        s.ce = bus.ram_ce; s.oe = bus.ram_oe; s.we = bus.ram_we; s.lb = bus.ram_lb; s.hb = bus.ram_hb;
        return s;
    endfunction

    task automatic checkOuts(input string name, input outs_t exp);
        outs_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: outputs got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic idleInputs();
        bus.vid_req = 1'b0;  bus.vid_addr = '0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0;
        bus.host_wdata = '0; bus.host_be = '0;
        dinVec = '0;
    endtask

    vec_t  vecs[22];
    outs_t zeroOuts;

    initial begin
        bit   grants[$];
        int   vidG;
        int   hostG;
        int   k;
        int   rvCount;
        int   prevCyc;
        int   cyc;
        int   hostExp;

        // ---- vector table: inputs applied before an edge, outputs seen after it ----
        //         vr va       hr hw ha       hdat     be     din        vg vv vd        hg hv hd        ad       dout     ce oe we lb hb
        vecs[0]  = mk(1,'h00123,0,0,'h0,    'h0,    2'b00,'h0,     1,0,'h0,     0,0,'h0,     'h00123,'h0,    1,1,0,1,1);
        vecs[1]  = mk(0,'h00123,0,0,'h0,    'h0,    2'b00,'hBEEF,  0,0,'h0,     0,0,'h0,     'h00123,'h0,    1,1,0,1,1);
        vecs[2]  = mk(0,'h0,    0,0,'h0,    'h0,    2'b00,'hBEEF,  0,1,'hBEEF,  0,0,'h0,     'h00123,'h0,    0,0,0,0,0);
        vecs[3]  = mk(0,'h0,    0,0,'h0,    'h0,    2'b00,'h0,     0,0,'hBEEF,  0,0,'h0,     'h00123,'h0,    0,0,0,0,0);
        vecs[4]  = mk(1,'h00200,1,0,'h00300,'h0,    2'b00,'h0,     1,0,'hBEEF,  0,0,'h0,     'h00200,'h0,    1,1,0,1,1);
        vecs[5]  = mk(0,'h0,    1,0,'h00300,'h0,    2'b00,'h1111,  0,0,'hBEEF,  0,0,'h0,     'h00200,'h0,    1,1,0,1,1);
        vecs[6]  = mk(0,'h0,    1,0,'h00300,'h0,    2'b00,'h1111,  0,1,'h1111,  1,0,'h0,     'h00300,'h0,    1,1,0,1,1);
        vecs[7]  = mk(0,'h0,    0,0,'h0,    'h0,    2'b00,'h2222,  0,0,'h1111,  0,0,'h0,     'h00300,'h0,    1,1,0,1,1);
        vecs[8]  = mk(0,'h0,    0,0,'h0,    'h0,    2'b00,'h2222,  0,0,'h1111,  0,1,'h2222,  'h00300,'h0,    0,0,0,0,0);
        vecs[9]  = mk(0,'h0,    0,0,'h0,    'h0,    2'b00,'h0,     0,0,'h1111,  0,0,'h2222,  'h00300,'h0,    0,0,0,0,0);
        vecs[10] = mk(0,'h0,    1,1,'h00010,'hA55A, 2'b01,'h0,     0,0,'h1111,  1,0,'h2222,  'h00010,'hA55A, 1,0,1,1,0);
        vecs[11] = mk(1,'h00400,0,0,'h0,    'h0,    2'b00,'h0,     0,0,'h1111,  0,0,'h2222,  'h00010,'hA55A, 1,0,1,1,0);
        vecs[12] = mk(1,'h00400,0,0,'h0,    'h0,    2'b00,'h0,     0,0,'h1111,  0,0,'h2222,  'h00010,'hA55A, 0,0,0,0,0);
        vecs[13] = mk(1,'h00400,0,0,'h0,    'h0,    2'b00,'h0,     0,0,'h1111,  0,0,'h2222,  'h00010,'hA55A, 0,0,0,0,0);
        vecs[14] = mk(1,'h00400,0,0,'h0,    'h0,    2'b00,'h0,     1,0,'h1111,  0,0,'h2222,  'h00400,'hA55A, 1,1,0,1,1);
        vecs[15] = mk(0,'h0,    0,0,'h0,    'h0,    2'b00,'h3333,  0,0,'h1111,  0,0,'h2222,  'h00400,'hA55A, 1,1,0,1,1);
        vecs[16] = mk(0,'h0,    0,0,'h0,    'h0,    2'b00,'h3333,  0,1,'h3333,  0,0,'h2222,  'h00400,'hA55A, 0,0,0,0,0);
        vecs[17] = mk(0,'h0,    0,0,'h0,    'h0,    2'b00,'h0,     0,0,'h3333,  0,0,'h2222,  'h00400,'hA55A, 0,0,0,0,0);
        vecs[18] = mk(0,'h0,    1,1,'h00020,'h0F0F, 2'b00,'h0,     0,0,'h3333,  1,0,'h2222,  'h00020,'h0F0F, 1,0,1,0,0);
        vecs[19] = mk(0,'h0,    0,0,'h0,    'h0,    2'b00,'h0,     0,0,'h3333,  0,0,'h2222,  'h00020,'h0F0F, 1,0,1,0,0);
        vecs[20] = mk(0,'h0,    0,0,'h0,    'h0,    2'b00,'h0,     0,0,'h3333,  0,0,'h2222,  'h00020,'h0F0F, 0,0,0,0,0);
        vecs[21] = mk(0,'h0,    0,0,'h0,    'h0,    2'b00,'h0,     0,0,'h3333,  0,0,'h2222,  'h00020,'h0F0F, 0,0,0,0,0);
        zeroOuts = '0;

        // ---- reset state ----
        useModel = 1'b0;
        idleInputs();
        reset = 1'b1;
        tick();
        tick();
        checkOuts("reset_values", zeroOuts);
        reset = 1'b0;
        tick();
        checkOuts("idle_after_reset", zeroOuts);

        // ---- table: video read, simultaneous requests, writes with TURN ----
        for (int i = 0; i < 22; i++) begin
            bus.vid_req    = vecs[i].vr;
            bus.vid_addr   = vecs[i].va;
            bus.host_req   = vecs[i].hr;
            bus.host_we    = vecs[i].hw;
            bus.host_addr  = vecs[i].ha;
            bus.host_wdata = vecs[i].hdat;
            bus.host_be    = vecs[i].be;
            dinVec         = vecs[i].din;
            tick();
            checkOuts($sformatf("vec%0d", i), vecs[i].exp);
        end

        // ---- both requesters held high: fairness pattern or pure video priority ----
        useModel = 1'b1;
        idleInputs();
        tick();
        bus.vid_req   = 1'b1; bus.vid_addr  = 18'h00777;
        bus.host_req  = 1'b1; bus.host_addr = 18'h00888; bus.host_we = 1'b0;
        vidG = 0;
        hostG = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (bus.vid_gnt && bus.host_gnt) begin
                checkInt("dual_gnt", 1, 0);
            end
            if (bus.vid_gnt) begin
                vidG++;
                grants.push_back(1'b0);
            end
            if (bus.host_gnt) begin
                hostG++;
                grants.push_back(1'b1);
            end
        end
        idleInputs();
        for (int c = 0; c < 4; c++) tick();
        checkInt("held_total_grants", vidG + hostG, 100);
        hostExp = FAIR ? 11 : 0;
        checkInt("held_host_grants", hostG, hostExp);
        for (int g = 0; g < grants.size() && g < 27; g++) begin
            checkInt($sformatf("held_grant%0d_is_host", g), int'(grants[g]),
                     (FAIR && (g % 9 == 8)) ? 1 : 0);
        end

        // ---- reset during second strobe cycle of a read ----
        bus.vid_req = 1'b1; bus.vid_addr = 18'h00055;
        tick();
        checkInt("abort_gnt", int'(bus.vid_gnt), 1);
        bus.vid_req = 1'b0;
        tick();
        checkInt("abort_strobe_before_reset", int'(bus.ram_ce && bus.ram_oe), 1);
        reset = 1'b1;
        tick();
        checkOuts("abort_reset_edge", zeroOuts);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOuts($sformatf("abort_after%0d", c), zeroOuts);
        end

        // ---- 100 back-to-back video reads ----
        k = 0;
        rvCount = 0;
        prevCyc = 0;
        cyc = 0;
        bus.vid_req  = 1'b1;
        bus.vid_addr = 18'h01000;
        while (rvCount < 100 && cyc < 600) begin
            tick();
            cyc++;
            if (bus.vid_gnt) begin
                k++;
                if (k < 100) bus.vid_addr = 18'h01000 + 18'(k);
                else         bus.vid_req  = 1'b0;
            end
            if (bus.vid_rvalid) begin
                checkInt($sformatf("stream_data%0d", rvCount), int'(bus.vid_rdata),
                         int'(memWord(18'h01000 + 18'(rvCount))));
                if (rvCount > 0) checkInt($sformatf("stream_gap%0d", rvCount), cyc - prevCyc, 2);
                prevCyc = cyc;
                rvCount++;
            end
        end
        checkInt("stream_rvalid_count", rvCount, 100);
        checkInt("stream_host_idle", int'(bus.host_rvalid || bus.host_gnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
